line_scheduler: RTL and testbench

Work-queue controller that sequences the fifo_solver datapath across all rows and columns of the board. It holds a deduplicated circular queue of pending line indices and looks up each line's option count from the option-count BRAM. It dispatches one line at a time to the solver with a valid/ready handshake, waits for the solver's result, and re-enqueues lines the solver reports as affected. Done is raised when the queue drains with nothing in flight; error is raised when any line reaches zero options.

---
 rtl/line_scheduler.sv | 175 +++++++++++++++++
 tb/tb_line_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_scheduler.sv
// Work-queue controller: walks every row/column line through the solver, re-queuing
// lines the solver flags as affected until the queue drains or a line runs out of options.
module line_scheduler #(
    parameter  int SIZE  = 3,
    parameter  int OPT_W = 4,
    localparam int LW    = $clog2(2 * SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [LW-1:0]    cnt_addr,
    input  logic [OPT_W-1:0] cnt_data,
    output logic             disp_valid,
    input  logic             disp_ready,
    output logic [LW-1:0]    line_ind,
    output logic             row,
    output logic [OPT_W-1:0] option_num,
    input  logic             res_valid,
    input  logic [OPT_W-1:0] res_opt_num,
    input  logic             rq_valid,
    input  logic [LW-1:0]    rq_line,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       state_dbg
);

    localparam int NL = 2 * SIZE;
    localparam int CW = LW + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_POP      = 3'd2,
        S_READ     = 3'd3,
        S_DISPATCH = 3'd4,
        S_WAIT     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t state_q, state_n;

    logic [LW-1:0] head_q, tail_q, init_idx_q;
    logic [CW-1:0] count_q;
    logic [NL-1:0] inq_q;
    logic [LW-1:0] q_buf [NL];

    logic          start_go, busy_state;
    logic          pop_en, rq_ok, init_ok;
    logic [LW-1:0] pop_line, ins_ptr, head_n, tail_n;
    logic [CW-1:0] count_n;
    logic [NL-1:0] inq_eff, inq_n;
    logic          disp_valid_n, busy_n, done_n;

    // The solver's own count is informational; the BRAM stays the source of truth.
    logic unused_res;
    assign unused_res = ^res_opt_num;

    function automatic logic [LW-1:0] wrap_inc(input logic [LW-1:0] p);
        if (32'(p) == NL - 1) return '0;
        return p + LW'(1);
    endfunction

    assign start_go   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign busy_state = (state_q != S_IDLE) && (state_q != S_DONE);
    assign state_dbg  = state_q;

    // Queue update: at most one pop plus a requeue push and an INIT push per cycle.
    // A popped line's inq bit is released first so it can be re-pushed the same cycle.
    always_comb begin
        pop_en   = (state_q == S_POP) && (count_q != '0);
        pop_line = q_buf[head_q];
        inq_eff  = inq_q;
        if (pop_en) inq_eff[pop_line] = 1'b0;

        rq_ok   = rq_valid && busy_state && (32'(rq_line) < NL) && !inq_eff[rq_line];
        init_ok = (state_q == S_INIT) && !inq_eff[init_idx_q]
                  && !(rq_ok && (rq_line == init_idx_q));

        ins_ptr = rq_ok ? wrap_inc(tail_q) : tail_q;
        tail_n  = init_ok ? wrap_inc(ins_ptr) : ins_ptr;
        head_n  = pop_en ? wrap_inc(head_q) : head_q;
        count_n = count_q + CW'(rq_ok) + CW'(init_ok) - CW'(pop_en);

        inq_n = inq_eff;
        if (rq_ok)   inq_n[rq_line]    = 1'b1;
        if (init_ok) inq_n[init_idx_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rq_ok)   q_buf[tail_q]  <= rq_line;
        if (init_ok) q_buf[ins_ptr] <= init_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inq_q      <= '0;
            init_idx_q <= '0;
        end else if (start_go) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inq_q      <= '0;
            init_idx_q <= '0;
        end else begin
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
            inq_q   <= inq_n;
            if (state_q == S_INIT) init_idx_q <= init_idx_q + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    // Dispatch handshake: disp_valid holds with line_ind/row/option_num stable until
    // the cycle disp_ready is also high; that cycle is the single transfer.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE:     if (start) state_n = S_INIT;
            S_INIT:     if (32'(init_idx_q) == NL - 1) state_n = S_POP;
            S_POP:      state_n = (count_q == '0) ? S_DONE : S_READ;
            S_READ: begin
                if (cnt_data == '0)               state_n = S_DONE;
                else if (cnt_data == OPT_W'(1))   state_n = S_POP;
                else                              state_n = S_DISPATCH;
            end
            S_DISPATCH: if (disp_ready) state_n = S_WAIT;
            S_WAIT:     if (res_valid)  state_n = S_POP;
            S_DONE:     if (start)      state_n = S_INIT;
            default:    state_n = S_IDLE;
        endcase
    end

    always_comb begin
        disp_valid_n = (state_n == S_DISPATCH);
        busy_n       = (state_n != S_IDLE) && (state_n != S_DONE);
        done_n       = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cnt_addr   <= '0;
            line_ind   <= '0;
            row        <= 1'b0;
            option_num <= '0;
        end else begin
            disp_valid <= disp_valid_n;
            busy       <= busy_n;
            done       <= done_n;
            if (pop_en) begin
                cnt_addr <= pop_line;
                line_ind <= pop_line;
                row      <= (32'(pop_line) < SIZE);
            end
            if (state_q == S_READ) option_num <= cnt_data;
            if (start_go)
                error <= 1'b0;
            else if ((state_q == S_READ) && (cnt_data == '0))
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_line_scheduler.sv
// Bench for line_scheduler: directed table of boards, hand-written corner sequences,
// and randomized handshakes/requeues checked against a transaction-level queue model.
module tb_line_scheduler;

    localparam int SIZE  = 3;
    localparam int OPT_W = 4;
    localparam int LW    = 3;
    localparam int NL    = 2 * SIZE;
    localparam int K_DISP = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LW-1:0]    cnt_addr;
    logic [OPT_W-1:0] cnt_data;
    logic             disp_valid;
    logic             disp_ready = 1'b0;
    logic [LW-1:0]    line_ind;
    logic             row;
    logic [OPT_W-1:0] option_num;
    logic             res_valid = 1'b0;
    logic [OPT_W-1:0] res_opt_num = '0;
    logic             rq_valid = 1'b0;
    logic [LW-1:0]    rq_line = '0;
    logic             busy, done, error;
    logic [2:0]       state_dbg;

    logic [OPT_W-1:0] cnt_mem [8];
    assign cnt_data = cnt_mem[cnt_addr];

    line_scheduler #(.SIZE(SIZE), .OPT_W(OPT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cnt_addr(cnt_addr), .cnt_data(cnt_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .line_ind(line_ind), .row(row), .option_num(option_num),
        .res_valid(res_valid), .res_opt_num(res_opt_num),
        .rq_valid(rq_valid), .rq_line(rq_line),
        .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int failures = 0;
    logic [LW+OPT_W-1:0] exp_q[$];
    int mq[$];
    int model_kind;
    int got_lines[$];

    typedef logic [NL-1:0][OPT_W-1:0] cnt_vec_t;
    typedef struct {
        cnt_vec_t      cnt;
        int            n_disp;
        logic [NL-1:0] mask;
        logic          err;
    } vec_t;
    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic cnt_vec_t cv(input int c0, c1, c2, c3, c4, c5);
        cnt_vec_t r;
        r[0] = OPT_W'(c0); r[1] = OPT_W'(c1); r[2] = OPT_W'(c2);
        r[3] = OPT_W'(c3); r[4] = OPT_W'(c4); r[5] = OPT_W'(c5);
        return r;
    endfunction

    // reference model: queue of pending lines with dedupe, walked one dispatch at a time
    task automatic model_push(input int l);
        if (l >= NL) return;
        foreach (mq[i]) if (mq[i] == l) return;
        mq.push_back(l);
    endtask

    task automatic model_advance();
        int l;
        model_kind = K_DONE;
        while (mq.size() > 0) begin
            l = mq.pop_front();
            if (cnt_mem[l] == 0) begin
                model_kind = K_ERR;
                mq.delete();
            end else if (cnt_mem[l] != 1) begin
                model_kind = K_DISP;
                exp_q.push_back({LW'(l), cnt_mem[l]});
                break;
            end
        end
    endtask

    // driver: serve dispatches until done, optionally with random backpressure/requeues
    task automatic service(input bit rand_hs, input bit use_model, input int budget);
        int cyc = 0;
        bit held = 0;
        logic [LW-1:0] h_line;
        logic [OPT_W-1:0] h_opt;
        logic [LW+OPT_W-1:0] e;
        int pend[$];
        int dly;
        while (!done && cyc < budget) begin
            if (disp_valid) begin
                if (held) begin
                    check("hold_line", line_ind, h_line);
                    check("hold_opt", option_num, h_opt);
                end
                disp_ready = 1'b1;
                if (rand_hs && $urandom_range(0, 2) == 0) disp_ready = 1'b0;
                if (!disp_ready) begin
                    held = 1;
                    h_line = line_ind;
                    h_opt = option_num;
                    step();
                    cyc++;
                end else begin
                    held = 0;
                    got_lines.push_back(int'(line_ind));
                    if (use_model) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_dispatch actual=%0d required=none", line_ind);
                        end else begin
                            e = exp_q.pop_front();
                            check("disp_line", line_ind, e[LW+OPT_W-1:OPT_W]);
                            check("disp_opt", option_num, e[OPT_W-1:0]);
                            check("disp_row", row, (int'(e[LW+OPT_W-1:OPT_W]) < SIZE));
                        end
                    end
                    step();
                    disp_ready = 1'b0;
                    cyc++;
                    dly = rand_hs ? int'($urandom_range(0, 3)) : 1;
                    for (int i = 0; i < dly; i++) begin
                        if (rand_hs && got_lines.size() < 10 && $urandom_range(0, 2) == 0) begin
                            rq_valid = 1'b1;
                            rq_line = LW'($urandom_range(0, 7));
                            pend.push_back(int'(rq_line));
                        end
                        step();
                        rq_valid = 1'b0;
                        cyc++;
                    end
                    res_valid = 1'b1;
                    res_opt_num = OPT_W'($urandom_range(0, 15));
                    step();
                    res_valid = 1'b0;
                    cyc++;
                    if (use_model) begin
                        foreach (pend[i]) model_push(pend[i]);
                        pend.delete();
                        model_advance();
                    end
                end
            end else begin
                step();
                cyc++;
            end
        end
        check("done_reached", done, 1);
    endtask

    task automatic run_job(input bit rand_hs);
        got_lines.delete();
        exp_q.delete();
        mq.delete();
        for (int l = 0; l < NL; l++) mq.push_back(l);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_err_clear", error, 0);
        model_advance();
        service(rand_hs, 1'b1, 4000);
        check("end_error", error, (model_kind == K_ERR));
        check("model_drained", exp_q.size(), 0);
    endtask

    task automatic wait_disp(output int n);
        n = 0;
        while (!disp_valid && n < 40) begin
            step();
            n++;
        end
        check("disp_seen", disp_valid, 1);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int n;
        logic [NL-1:0] m;
        int exp_rq[6];

        vecs[0] = '{cnt: cv(3, 2, 2, 2, 3, 2),   n_disp: 6, mask: 6'b111111, err: 1'b0};
        vecs[1] = '{cnt: cv(3, 2, 2, 2, 1, 2),   n_disp: 5, mask: 6'b101111, err: 1'b0};
        vecs[2] = '{cnt: cv(3, 2, 0, 2, 3, 2),   n_disp: 2, mask: 6'b000011, err: 1'b1};
        vecs[3] = '{cnt: cv(1, 1, 1, 1, 1, 1),   n_disp: 0, mask: 6'b000000, err: 1'b0};
        vecs[4] = '{cnt: cv(0, 2, 2, 2, 2, 2),   n_disp: 0, mask: 6'b000000, err: 1'b1};
        vecs[5] = '{cnt: cv(15, 1, 15, 1, 15, 0), n_disp: 3, mask: 6'b010101, err: 1'b1};
        vecs[6] = '{cnt: cv(2, 1, 1, 1, 1, 9),   n_disp: 2, mask: 6'b100001, err: 1'b0};
        for (int l = 0; l < 8; l++) cnt_mem[l] = '0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_disp_valid", disp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cnt_addr", cnt_addr, 0);
        check("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        step();

        // latency, first dispatch, then reset while in WAIT
        for (int l = 0; l < NL; l++) cnt_mem[l] = 4'd2;
        start_pulse();
        wait_disp(n);
        check("start_to_disp", n, 2 * SIZE + 2);
        check("first_line", line_ind, 0);
        check("first_row", row, 1);
        check("first_opt", option_num, 2);
        disp_ready = 1'b1;
        step();
        disp_ready = 1'b0;
        check("wait_busy", busy, 1);
        check("wait_no_valid", disp_valid, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_line", line_ind, 0);
        check("arst_opt", option_num, 0);
        check("arst_state", state_dbg, 0);
        step();
        rst_n = 1'b1;
        step();

        // directed table of boards
        foreach (vecs[v]) begin
            for (int l = 0; l < NL; l++) cnt_mem[l] = vecs[v].cnt[l];
            run_job(1'b0);
            check("tbl_n_disp", got_lines.size(), vecs[v].n_disp);
            m = '0;
            foreach (got_lines[i]) m[got_lines[i]] = 1'b1;
            check("tbl_mask", m, vecs[v].mask);
            check("tbl_error", error, vecs[v].err);
        end

        // requeue dedupe: line 3 already queued, line 0 re-enters at the tail
        for (int l = 0; l < NL; l++) cnt_mem[l] = 4'd2;
        start_pulse();
        check("restart_err_clear", error, 0);
        wait_disp(n);
        disp_ready = 1'b1;
        step();
        disp_ready = 1'b0;
        rq_valid = 1'b1;
        rq_line = 3'd3;
        step();
        rq_line = 3'd0;
        step();
        rq_valid = 1'b0;
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        step();
        check("res_to_addr", cnt_addr, 1);
        got_lines.delete();
        service(1'b0, 1'b0, 500);
        exp_rq = '{1, 2, 3, 4, 5, 0};
        check("rq_n_disp", got_lines.size(), 6);
        if (got_lines.size() == 6)
            foreach (exp_rq[i]) check("rq_order", got_lines[i], exp_rq[i]);

        // backpressure: four stalled cycles then exactly one transfer
        for (int l = 0; l < NL; l++) cnt_mem[l] = vecs[0].cnt[l];
        start_pulse();
        wait_disp(n);
        for (int i = 0; i < 4; i++) begin
            disp_ready = 1'b0;
            step();
            check("bp_valid", disp_valid, 1);
            check("bp_line", line_ind, 0);
            check("bp_opt", option_num, 3);
        end
        disp_ready = 1'b1;
        step();
        disp_ready = 1'b0;
        check("bp_single", disp_valid, 0);
        step();
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        got_lines.delete();
        service(1'b0, 1'b0, 500);
        check("bp_rest", got_lines.size(), 5);
        if (got_lines.size() > 0) check("bp_next_line", got_lines[0], 1);

        // randomized boards, handshakes and requeues against the model
        for (int j = 0; j < 25; j++) begin
            for (int l = 0; l < NL; l++)
                cnt_mem[l] = ($urandom_range(0, 24) == 0) ? 4'd0 : OPT_W'($urandom_range(1, 6));
            run_job(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
